// File: rtl/bool_equiv_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bool_equiv_checker_if                                         |
// | Purpose  : Bundles the stimulus bus, function-block results and          |
// |            checker results of bool_equiv_checker.                        |
// | Signals  : start        request to begin a sweep                         |
// |            vec          current input vector driven to f_a / f_b blocks  |
// |            f_a, f_b     results of the two function blocks for vec       |
// |            busy, done   sweep in progress / one-cycle results-valid      |
// |            equal        all vectors matched                              |
// |            mism_cnt     number of mismatching vectors (N+1 bits)         |
// |            first_mism   lowest mismatching vector                        |
// |            truth_a/b    sampled truth tables                             |
// | Modports : slave  = checker side, master = driver / function-block side  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface bool_equiv_checker_if #(
  parameter int N = 3
);
  logic                start;
  logic [N-1:0]        vec;
  logic                f_a;
  logic                f_b;
  logic                busy;
  logic                done;
  logic                equal;
  logic [N:0]          mism_cnt;
  logic [N-1:0]        first_mism;
  logic [(1<<N)-1:0]   truth_a;
  logic [(1<<N)-1:0]   truth_b;

  modport slave (
    input  start, f_a, f_b,
    output vec, busy, done, equal, mism_cnt, first_mism, truth_a, truth_b
  );

  modport master (
    output start, f_a, f_b,
    input  vec, busy, done, equal, mism_cnt, first_mism, truth_a, truth_b
  );
endinterface
`default_nettype wire

// File: rtl/bool_equiv_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bool_equiv_checker                                            |
// | Purpose  : Exhaustive sequential equivalence check of two N-input        |
// |            single-output Boolean functions. Sweeps vec over 0..2^N-1,    |
// |            holds each vector SETTLE+1 cycles, samples f_a/f_b, builds    |
// |            both truth tables, counts mismatches, records the first one.  |
// | Ports    : clk  rising-edge clock                                        |
// |            rst  synchronous active-high reset                            |
// |            bus  bool_equiv_checker_if.slave (see interface header)       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bool_equiv_checker #(
  parameter int N      = 3,
  parameter int SETTLE = 0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  bool_equiv_checker_if.slave   bus
);

  localparam int            W        = 1 << N;
  localparam logic [3:0]    SETTLE_C = 4'(SETTLE);
  localparam logic [N-1:0]  VEC_MAX  = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [N-1:0]    vec;
  logic [3:0]      hold_cnt;
  logic [N:0]      mism_cnt;
  logic [N-1:0]    first_mism;
  logic            seen_mism;
  logic            equal;
  logic [W-1:0]    truth_a;
  logic [W-1:0]    truth_b;
  logic            busy;
  logic            done;

  logic            sample;
  logic            last_vec;
  logic            diff;
  logic [N:0]      mism_next;

  // Sample edge = edge that closes the last hold cycle of the current vector.
  assign sample    = (state == SWEEP) && (hold_cnt == SETTLE_C);
  assign last_vec  = (vec == VEC_MAX);
  assign diff      = bus.f_a ^ bus.f_b;
  // Count including the vector being sampled now, so the final sample edge
  // can register equal from the complete count.
  assign mism_next = mism_cnt + {{N{1'b0}}, diff};

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = SWEEP;
      end
      SWEEP: begin
        busy = 1'b1;
        if (sample && last_vec) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      hold_cnt   <= '0;
      mism_cnt   <= '0;
      first_mism <= '0;
      seen_mism  <= 1'b0;
      equal      <= 1'b0;
      truth_a    <= '0;
      truth_b    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.start) begin
            vec        <= '0;
            hold_cnt   <= '0;
            mism_cnt   <= '0;
            first_mism <= '0;
            seen_mism  <= 1'b0;
            equal      <= 1'b0;
            truth_a    <= '0;
            truth_b    <= '0;
          end
        end
        SWEEP: begin
          if (sample) begin
            truth_a[vec] <= bus.f_a;
            truth_b[vec] <= bus.f_b;
            mism_cnt     <= mism_next;
            hold_cnt     <= '0;
            if (diff && !seen_mism) begin
              first_mism <= vec;
              seen_mism  <= 1'b1;
            end
            // vec saturates at the last vector; the sweep ends instead of wrapping.
            if (last_vec) equal <= (mism_next == '0);
            else          vec   <= vec + 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.vec        = vec;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.equal      = equal;
  assign bus.mism_cnt   = mism_cnt;
  assign bus.first_mism = first_mism;
  assign bus.truth_a    = truth_a;
  assign bus.truth_b    = truth_b;

endmodule
`default_nettype wire

// File: tb/tb_bool_equiv_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bool_equiv_checker                                         |
// | Purpose  : Self-checking bench for bool_equiv_checker (N=3). Instance 0  |
// |            uses combinational function blocks (SETTLE=0), instance 1    |
// |            uses 2-cycle registered blocks (SETTLE=2). Function blocks   |
// |            are truth-table lookups; expectations come from a truth-table |
// |            model of the comparison.                                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bool_equiv_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] tab_a = 8'h00;
  logic [7:0] tab_b = 8'h00;
  logic       pa1, pa2, pb1, pb2;

  always #5 clk = ~clk;

  bool_equiv_checker_if #(.N(3)) bus0 ();
  bool_equiv_checker_if #(.N(3)) bus1 ();

  bool_equiv_checker #(.N(3), .SETTLE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  bool_equiv_checker #(.N(3), .SETTLE(2)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.f_a = tab_a[bus0.vec];
  assign bus0.f_b = tab_b[bus0.vec];

  always @(posedge clk) begin
    pa1 <= tab_a[bus1.vec];
    pa2 <= pa1;
    pb1 <= tab_b[bus1.vec];
    pb2 <= pb1;
  end
  assign bus1.f_a = pa2;
  assign bus1.f_b = pb2;

  // kind 0: (x+y)(~x+z)(y+z); 1: (x+y)(~x+z); 2: (x+y)(y+z)
  function automatic logic [7:0] build(input int kind);
    logic [7:0] t;
    logic x, y, z;
    t = '0;
    for (int v = 0; v < 8; v++) begin
      x = v[0]; y = v[1]; z = v[2];
      case (kind)
        0:       t[v] = (x | y) & (~x | z) & (y | z);
        1:       t[v] = (x | y) & (~x | z);
        default: t[v] = (x | y) & (y | z);
      endcase
    end
    return t;
  endfunction

  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output int mism, output int first, output bit eq);
    mism = 0; first = 0;
    for (int i = 0; i < 8; i++)
      if (a[i] != b[i]) begin
        if (mism == 0) first = i;
        mism++;
      end
    eq = (mism == 0);
  endfunction

  // Pulses start on one instance and waits for done. cyc = edges from the
  // start edge to the done cycle (-1 on timeout). seq_ok clears if vec or
  // busy ever deviate from the expected hold schedule.
  task automatic sweep(input int which, output int cyc, output bit seq_ok);
    int  s1;
    logic d, b;
    logic [2:0] v;
    s1 = (which == 0) ? 1 : 3;
    @(negedge clk);
    if (which == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0; bus1.start = 1'b0;
    cyc = 0; seq_ok = 1'b1;
    d = (which == 0) ? bus0.done : bus1.done;
    while (!d && cyc < 200) begin
      v = (which == 0) ? bus0.vec : bus1.vec;
      b = (which == 0) ? bus0.busy : bus1.busy;
      if (int'(v) != cyc / s1 || !b) seq_ok = 1'b0;
      @(negedge clk);
      cyc++;
      d = (which == 0) ? bus0.done : bus1.done;
    end
    if (!d) cyc = -1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus0.busy, bus0.done, bus0.equal, bus0.mism_cnt, bus0.first_mism,
         bus0.truth_a, bus0.truth_b, bus0.vec} !== '0) begin
      miscompares++;
      $display("FAIL reset0: outputs %h required 0", {bus0.busy, bus0.done, bus0.equal,
               bus0.mism_cnt, bus0.first_mism, bus0.truth_a, bus0.truth_b, bus0.vec});
    end
    vectors++;
    if ({bus1.busy, bus1.done, bus1.equal, bus1.mism_cnt, bus1.first_mism,
         bus1.truth_a, bus1.truth_b, bus1.vec} !== '0) begin
      miscompares++;
      $display("FAIL reset1: outputs %h required 0", {bus1.busy, bus1.done, bus1.equal,
               bus1.mism_cnt, bus1.first_mism, bus1.truth_a, bus1.truth_b, bus1.vec});
    end
    rst = 1'b0;
  endtask

  task automatic test_consensus();
    int cyc; bit ok;
    tab_a = build(0); tab_b = build(1);
    sweep(0, cyc, ok);
    vectors++; if (cyc !== 8) begin miscompares++; $display("FAIL cons_latency: got %0d required 8", cyc); end
    vectors++; if (!ok) begin miscompares++; $display("FAIL cons_sequence: got 0 required 1"); end
    vectors++; if (bus0.equal !== 1'b1) begin miscompares++; $display("FAIL cons_equal: got %b required 1", bus0.equal); end
    vectors++; if (bus0.mism_cnt !== 4'd0) begin miscompares++; $display("FAIL cons_mism: got %0d required 0", bus0.mism_cnt); end
    vectors++; if (bus0.first_mism !== 3'd0) begin miscompares++; $display("FAIL cons_first: got %0d required 0", bus0.first_mism); end
    vectors++; if (bus0.truth_a !== 8'hE4) begin miscompares++; $display("FAIL cons_truth_a: got %h required e4", bus0.truth_a); end
    vectors++; if (bus0.truth_b !== 8'hE4) begin miscompares++; $display("FAIL cons_truth_b: got %h required e4", bus0.truth_b); end
  endtask

  task automatic test_wrong_option();
    int cyc; bit ok;
    tab_a = build(0); tab_b = build(2);
    sweep(0, cyc, ok);
    vectors++; if (bus0.truth_b !== 8'hEC) begin miscompares++; $display("FAIL wrong_truth_b: got %h required ec", bus0.truth_b); end
    vectors++; if (bus0.mism_cnt !== 4'd1) begin miscompares++; $display("FAIL wrong_mism: got %0d required 1", bus0.mism_cnt); end
    vectors++; if (bus0.first_mism !== 3'd3) begin miscompares++; $display("FAIL wrong_first: got %0d required 3", bus0.first_mism); end
    vectors++; if (bus0.equal !== 1'b0) begin miscompares++; $display("FAIL wrong_equal: got %b required 0", bus0.equal); end
  endtask

  task automatic test_full_mismatch();
    int cyc; bit ok;
    tab_a = build(0); tab_b = ~build(0);
    sweep(0, cyc, ok);
    vectors++; if (bus0.mism_cnt !== 4'b1000) begin miscompares++; $display("FAIL full_mism: got %b required 1000", bus0.mism_cnt); end
    vectors++; if (bus0.first_mism !== 3'd0) begin miscompares++; $display("FAIL full_first: got %0d required 0", bus0.first_mism); end
    vectors++; if (bus0.equal !== 1'b0) begin miscompares++; $display("FAIL full_equal: got %b required 0", bus0.equal); end
  endtask

  task automatic test_settle();
    int cyc; bit ok;
    tab_a = build(0); tab_b = build(1);
    sweep(1, cyc, ok);
    vectors++; if (cyc !== 24) begin miscompares++; $display("FAIL settle_latency: got %0d required 24", cyc); end
    vectors++; if (!ok) begin miscompares++; $display("FAIL settle_hold: got 0 required 1"); end
    vectors++; if (bus1.equal !== 1'b1) begin miscompares++; $display("FAIL settle_equal: got %b required 1", bus1.equal); end
    vectors++; if (bus1.truth_a !== 8'hE4) begin miscompares++; $display("FAIL settle_truth_a: got %h required e4", bus1.truth_a); end
  endtask

  task automatic test_random();
    int cyc, em, ef, w; bit ok, ee;
    logic eq_o; logic [3:0] m_o; logic [2:0] f_o; logic [7:0] ta_o, tb_o;
    for (int it = 0; it < 10; it++) begin
      w = it % 2;
      tab_a = 8'($urandom);
      tab_b = (it % 3 == 0) ? tab_a : 8'($urandom);
      model(tab_a, tab_b, em, ef, ee);
      sweep(w, cyc, ok);
      eq_o = (w == 0) ? bus0.equal : bus1.equal;
      m_o  = (w == 0) ? bus0.mism_cnt : bus1.mism_cnt;
      f_o  = (w == 0) ? bus0.first_mism : bus1.first_mism;
      ta_o = (w == 0) ? bus0.truth_a : bus1.truth_a;
      tb_o = (w == 0) ? bus0.truth_b : bus1.truth_b;
      vectors++; if (cyc !== 8 * (2 * w + 1)) begin miscompares++; $display("FAIL rand%0d_latency: got %0d required %0d", it, cyc, 8 * (2 * w + 1)); end
      vectors++; if (eq_o !== ee) begin miscompares++; $display("FAIL rand%0d_equal: got %b required %b", it, eq_o, ee); end
      vectors++; if (int'(m_o) !== em) begin miscompares++; $display("FAIL rand%0d_mism: got %0d required %0d", it, m_o, em); end
      vectors++; if (int'(f_o) !== ef) begin miscompares++; $display("FAIL rand%0d_first: got %0d required %0d", it, f_o, ef); end
      vectors++; if (ta_o !== tab_a || tb_o !== tab_b) begin
        miscompares++; $display("FAIL rand%0d_truth: got %h/%h required %h/%h", it, ta_o, tb_o, tab_a, tab_b);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, n; bit ok;
    tab_a = build(0); tab_b = build(2);
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    n = 0;
    while (bus0.vec !== 3'd4 && n < 50) begin @(negedge clk); n++; end
    vectors++; if (bus0.vec !== 3'd4) begin miscompares++; $display("FAIL rmid_reach: got vec %0d required 4", bus0.vec); end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus0.busy, bus0.done, bus0.equal, bus0.mism_cnt, bus0.first_mism,
         bus0.truth_a, bus0.truth_b, bus0.vec} !== '0) begin
      miscompares++;
      $display("FAIL rmid_clear: outputs %h required 0", {bus0.busy, bus0.done, bus0.equal,
               bus0.mism_cnt, bus0.first_mism, bus0.truth_a, bus0.truth_b, bus0.vec});
    end
    rst = 1'b0;
    sweep(0, cyc, ok);
    vectors++; if (cyc !== 8 || !ok) begin miscompares++; $display("FAIL rmid_resweep: got cyc %0d seq %b required 8 1", cyc, ok); end
    vectors++; if (bus0.mism_cnt !== 4'd1 || bus0.first_mism !== 3'd3 || bus0.truth_b !== 8'hEC) begin
      miscompares++; $display("FAIL rmid_results: got %0d/%0d/%h required 1/3/ec", bus0.mism_cnt, bus0.first_mism, bus0.truth_b);
    end
  endtask

  task automatic test_start_handling();
    int cyc;
    tab_a = build(0); tab_b = build(1);
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    cyc = 0;
    while (!bus0.done && cyc < 100) begin
      if (cyc == 3) bus0.start = 1'b1;
      if (cyc == 4) bus0.start = 1'b0;
      @(negedge clk); cyc++;
    end
    vectors++; if (cyc !== 8) begin miscompares++; $display("FAIL st_sweep_ignore: got %0d required 8", cyc); end
    bus0.start = 1'b1;  // during the DONE cycle: must be ignored
    @(negedge clk);
    vectors++; if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
      miscompares++; $display("FAIL st_done_ignore: got busy %b done %b required 0 0", bus0.busy, bus0.done);
    end
    vectors++; if (bus0.equal !== 1'b1 || bus0.truth_a !== 8'hE4 || bus0.truth_b !== 8'hE4) begin
      miscompares++; $display("FAIL st_intact: got %b/%h/%h required 1/e4/e4", bus0.equal, bus0.truth_a, bus0.truth_b);
    end
    @(negedge clk);  // start held through the first IDLE cycle: accepted
    bus0.start = 1'b0;
    vectors++; if (bus0.busy !== 1'b1 || bus0.vec !== 3'd0) begin
      miscompares++; $display("FAIL st_accept: got busy %b vec %0d required 1 0", bus0.busy, bus0.vec);
    end
    vectors++; if ({bus0.equal, bus0.mism_cnt, bus0.first_mism, bus0.truth_a, bus0.truth_b} !== '0) begin
      miscompares++; $display("FAIL st_cleared: got %h required 0", {bus0.equal, bus0.mism_cnt,
               bus0.first_mism, bus0.truth_a, bus0.truth_b});
    end
    cyc = 0;
    while (!bus0.done && cyc < 100) begin @(negedge clk); cyc++; end
    vectors++; if (bus0.done !== 1'b1 || bus0.equal !== 1'b1) begin
      miscompares++; $display("FAIL st_finish: got done %b equal %b required 1 1", bus0.done, bus0.equal);
    end
  endtask

  initial begin
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    test_reset();
    test_consensus();
    test_wrong_option();
    test_full_mismatch();
    test_settle();
    test_random();
    test_reset_mid();
    test_start_handling();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
